alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 141 ++++++++++++++
 tb/tb_alu_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU with pass-through tag and flags.
// Optional sticky overflow flag enabled by ALU_PIPE_STICKY_OVF_EN.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       command,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag,
  input  logic             sticky_clr,
  output logic             sticky_ovf
);

  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_XOR  = 3'd2;
  localparam logic [2:0] CMD_SLT  = 3'd3;
  localparam logic [2:0] CMD_AND  = 3'd4;
  localparam logic [2:0] CMD_NAND = 3'd5;
  localparam logic [2:0] CMD_OR   = 3'd6;
  localparam logic [2:0] CMD_NOR  = 3'd7;

  logic             s1_valid;
  logic [2:0]       s1_cmd;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [TAG_W-1:0] s1_tag;

  logic s2_load;
  logic s1_load;
  logic accept;

  assign s2_load   = !out_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_cmd   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else if (s1_load) begin
      s1_valid <= accept;
      if (accept) begin
        s1_cmd <= command;
        s1_a   <= a;
        s1_b   <= b;
        s1_tag <= in_tag;
      end
    end
  end

  logic             sub_mode;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic             ovf_raw;
  logic             lt;
  logic [WIDTH-1:0] res_c;
  logic             co_c;
  logic             ov_c;

  // SLT reuses the subtractor; sign ^ overflow gives the true signed compare
  always_comb begin
    sub_mode = (s1_cmd == CMD_SUB) || (s1_cmd == CMD_SLT);
    b_op     = sub_mode ? ~s1_b : s1_b;
    sum      = {1'b0, s1_a} + {1'b0, b_op}
             + {{WIDTH{1'b0}}, sub_mode};
    ovf_raw  = (s1_a[WIDTH-1] == b_op[WIDTH-1])
            && (sum[WIDTH-1] != s1_a[WIDTH-1]);
    lt       = sum[WIDTH-1] ^ ovf_raw;
    res_c    = '0;
    co_c     = 1'b0;
    ov_c     = 1'b0;
    unique case (s1_cmd)
      CMD_ADD, CMD_SUB: begin
        res_c = sum[WIDTH-1:0];
        co_c  = sum[WIDTH];
        ov_c  = ovf_raw;
      end
      CMD_XOR:  res_c = s1_a ^ s1_b;
      CMD_SLT:  res_c = {{(WIDTH-1){1'b0}}, lt};
      CMD_AND:  res_c = s1_a & s1_b;
      CMD_NAND: res_c = ~(s1_a & s1_b);
      CMD_OR:   res_c = s1_a | s1_b;
      CMD_NOR:  res_c = ~(s1_a | s1_b);
      default:  res_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      carryout  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_tag   <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result   <= res_c;
        carryout <= co_c;
        overflow <= ov_c;
        zero     <= ~|res_c;
        out_tag  <= s1_tag;
      end
    end
  end

`ifdef ALU_PIPE_STICKY_OVF_EN
  logic sticky_q;
  always_ff @(posedge clk) begin
    if (reset)
      sticky_q <= 1'b0;
    else if (out_valid && out_ready && overflow)
      sticky_q <= 1'b1;
    else if (sticky_clr)
      sticky_q <= 1'b0;
  end
  assign sticky_ovf = sticky_q;
`else
  // Feature off: tie low while still consuming sticky_clr
  assign sticky_ovf = sticky_clr & 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=32, TAG_W=4).
// Sticky checks follow ALU_PIPE_STICKY_OVF_EN.
module tb_alu_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  command;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carryout;
  logic        overflow;
  logic        zero;
  logic [3:0]  out_tag;
  logic        sticky_clr;
  logic        sticky_ovf;

  alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .command(command), .a(a), .b(b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carryout(carryout),
    .overflow(overflow), .zero(zero),
    .out_tag(out_tag),
    .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        co;
    logic        ov;
    logic        z;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output tag=%h res=%h",
                 out_tag, result);
      end else begin
        e = sb.pop_front();
        if ({result, carryout, overflow, zero, out_tag} !== e) begin
          failures++;
          $display("FAIL result_tag%0d actual=%h expected=%h",
                   e.tag, {result, carryout, overflow, zero, out_tag}, e);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] c, input logic [31:0] x,
                      input logic [31:0] y, input logic [3:0] t,
                      input logic [31:0] r, input logic co,
                      input logic ov, input logic z);
    bit ok;
    int n;
    ok = 0;
    n = 0;
    in_valid = 1'b1;
    command = c; a = x; b = y; in_tag = t;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready;
      n++;
      tick();
    end
    in_valid = 1'b0;
    if (ok) sb.push_back({r, co, ov, z, t});
    else chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    command = '0; a = '0; b = '0; in_tag = '0; sticky_clr = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_flags", 64'({carryout, overflow, zero}), 64'd0);
    chk("rst_sticky", 64'(sticky_ovf), 64'd0);
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_no_output", 64'(out_valid), 64'd0);

    // latency: offer after edge N, result visible after edge N+2
    in_valid = 1'b1; command = 3'd0;
    a = 32'h7FFF_FFFF; b = 32'h1; in_tag = 4'd1;
    sb.push_back({32'h8000_0000, 1'b0, 1'b1, 1'b0, 4'd1});
    tick();
    in_valid = 1'b0;
    chk("lat_edge1", 64'(out_valid), 64'd0);
    tick();
    chk("lat_edge2", 64'(out_valid), 64'd1);
    drain();

    send(3'd1, 32'h8000_0000, 32'h1, 4'd2, 32'h7FFF_FFFF, 1, 1, 0);
    send(3'd3, 32'h8000_0000, 32'h1, 4'd3, 32'h1, 0, 0, 0);
    send(3'd2, 32'hAAAA_AAAA, 32'h5555_5555, 4'd4, 32'hFFFF_FFFF, 0, 0, 0);
    send(3'd7, 32'hAAAA_AAAA, 32'h5555_5555, 4'd5, 32'h0, 0, 0, 1);
    send(3'd0, 32'hFFFF_FFFF, 32'h1, 4'd6, 32'h0, 1, 0, 1);
    send(3'd4, 32'hAAAA_AAAA, 32'hFFFF_0000, 4'd7, 32'hAAAA_0000, 0, 0, 0);
    send(3'd5, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 4'd8, 32'h0F0F_0F0F, 0, 0, 0);
    send(3'd6, 32'h1234_0000, 32'h0000_5678, 4'd9, 32'h1234_5678, 0, 0, 0);
    send(3'd1, 32'h5, 32'h5, 4'd10, 32'h0, 1, 0, 1);
    send(3'd1, 32'h3, 32'h5, 4'd11, 32'hFFFF_FFFE, 0, 0, 0);
    send(3'd3, 32'h1, 32'h8000_0000, 4'd12, 32'h0, 0, 0, 1);
    send(3'd3, 32'h7FFF_FFFF, 32'h8000_0000, 4'd13, 32'h0, 0, 0, 1);
    send(3'd3, 32'hFFFF_FFFF, 32'h0, 4'd14, 32'h1, 0, 0, 0);
    send(3'd0, 32'h8000_0000, 32'h8000_0000, 4'd15, 32'h0, 1, 1, 1);
    drain();

    // backpressure: capacity two, outputs held
    out_ready = 1'b0;
    in_valid = 1'b1; command = 3'd0; b = 32'h1;
    a = 32'd0; in_tag = 4'd0;
    sb.push_back({32'd1, 1'b0, 1'b0, 1'b0, 4'd0});
    tick();
    a = 32'd1; in_tag = 4'd1;
    sb.push_back({32'd2, 1'b0, 1'b0, 1'b0, 4'd1});
    tick();
    a = 32'd2; in_tag = 4'd2;
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_tag0", 64'({out_valid, out_tag}), 64'h10);
    tick(); tick();
    chk("stall_hold", 64'({out_valid, out_tag, result}), 64'h10_0000_0001);
    chk("stall_in_ready2", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    sb.push_back({32'd3, 1'b0, 1'b0, 1'b0, 4'd2});
    tick();
    in_valid = 1'b0;
    chk("seq_tag1", 64'({out_valid, out_tag}), 64'h11);
    tick();
    chk("seq_tag2", 64'({out_valid, out_tag}), 64'h12);
    drain();

    // reset with two ops in flight
    out_ready = 1'b0;
    send(3'd0, 32'd10, 32'd20, 4'd3, 32'd30, 0, 0, 0);
    send(3'd0, 32'd11, 32'd20, 4'd4, 32'd31, 0, 0, 0);
    sb.delete();
    reset = 1'b1; in_valid = 1'b1; in_tag = 4'd9;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("flush_no_stale", 64'(out_valid), 64'd0);
    end

    // sticky overflow: set beats clear in the same cycle
    out_ready = 1'b0;
    send(3'd0, 32'h7FFF_FFFF, 32'h1, 4'd5, 32'h8000_0000, 0, 1, 0);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    chk("sticky_pre", 64'(sticky_ovf), 64'd0);
    out_ready = 1'b1; sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
`ifdef ALU_PIPE_STICKY_OVF_EN
    chk("sticky_set_wins", 64'(sticky_ovf), 64'd1);
    tick();
    chk("sticky_holds", 64'(sticky_ovf), 64'd1);
`else
    chk("sticky_off", 64'(sticky_ovf), 64'd0);
    tick();
`endif
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("sticky_cleared", 64'(sticky_ovf), 64'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
